x_uart_rx_frame: RTL

//   Frame decoder directly downstream of the UART receiver. Consumes its byte stream
//   (i_valid/i_data) and assembles register-write commands for the delay-line control

---
 rtl/x_uart_rx_frame.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/x_uart_rx_frame.sv
// Frame decoder behind the UART receiver: SYNC, ADDR, DATA_HI, DATA_LO[, CHK] -> one register-write command.
// Optional macro X_UART_RX_FRAME_CHECKSUM_EN adds the trailing XOR checksum byte.
module x_uart_rx_frame #(
    parameter int          p_clk_hz     = 1000000,
    parameter int          p_baud       = 9600,
    parameter int          p_timeout_by = 2,
    parameter logic [7:0]  p_sync       = 8'hA5
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_valid,
    input  logic [7:0]  i_data,
    output logic        o_wr_valid,
    input  logic        i_wr_ready,
    output logic [7:0]  o_wr_addr,
    output logic [15:0] o_wr_data,
    output logic        o_err_valid,
    output logic [1:0]  o_err_code
);

    localparam int LP_TOP = p_timeout_by * 10 * (p_clk_hz / p_baud);
    localparam int LP_TW  = $clog2(LP_TOP + 1);
    localparam logic [LP_TW-1:0] LP_TOP_M1 = LP_TW'(LP_TOP - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_DHI  = 3'd2;
    localparam logic [2:0] S_DLO  = 3'd3;
    localparam logic [2:0] S_CHK  = 3'd4;
    localparam logic [2:0] S_OUT  = 3'd5;

    logic [2:0]       r_state;
    logic [LP_TW-1:0] r_timer;
    logic [7:0]       r_addr;
    logic [7:0]       r_dhi;
    logic [7:0]       r_dlo;
    logic             r_wr_valid;
    logic             r_err_valid;
    logic [1:0]       r_err_code;

    logic [2:0]       w_state_nxt;
    logic [LP_TW-1:0] w_timer_nxt;
    logic             w_wr_valid_nxt;
    logic             w_err_valid;
    logic [1:0]       w_err_code;
    logic             w_ld_addr;
    logic             w_ld_dhi;
    logic             w_ld_dlo;
    logic             w_is_sync;

    assign w_is_sync = i_valid & (i_data == p_sync);

`ifdef X_UART_RX_FRAME_CHECKSUM_EN
    logic [7:0] w_chk;
    assign w_chk = r_addr ^ r_dhi ^ r_dlo;
`endif

    // Next-state, timer, load strobes and error selection
    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = {LP_TW{1'b0}};
        w_wr_valid_nxt = r_wr_valid;
        w_err_valid    = 1'b0;
        w_err_code     = 2'd0;
        w_ld_addr      = 1'b0;
        w_ld_dhi       = 1'b0;
        w_ld_dlo       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_is_sync) begin
                    w_state_nxt = S_ADDR;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ADDR, S_DHI, S_DLO, S_CHK: begin
                if (i_valid) begin
                    case (r_state)
                        S_ADDR: begin
                            w_ld_addr   = 1'b1;
                            w_state_nxt = S_DHI;
                        end
                        S_DHI: begin
                            w_ld_dhi    = 1'b1;
                            w_state_nxt = S_DLO;
                        end
                        S_DLO: begin
                            w_ld_dlo = 1'b1;
`ifdef X_UART_RX_FRAME_CHECKSUM_EN
                            w_state_nxt = S_CHK;
`else
                            w_state_nxt    = S_OUT;
                            w_wr_valid_nxt = 1'b1;
`endif
                        end
`ifdef X_UART_RX_FRAME_CHECKSUM_EN
                        S_CHK: begin
                            if (i_data == w_chk) begin
                                w_state_nxt    = S_OUT;
                                w_wr_valid_nxt = 1'b1;
                            end else begin
                                w_state_nxt = S_IDLE;
                                w_err_valid = 1'b1;
                                w_err_code  = 2'd2;
                            end
                        end
`endif
                        default: begin
                            w_state_nxt = S_IDLE;
                        end
                    endcase
                end else if (r_timer == LP_TOP_M1) begin
                    // Timer would reach top on this edge: abandon the frame
                    w_state_nxt = S_IDLE;
                    w_err_valid = 1'b1;
                    w_err_code  = 2'd1;
                end else begin
                    w_timer_nxt = r_timer + {{(LP_TW-1){1'b0}}, 1'b1};
                end
            end
            S_OUT: begin
                if (r_wr_valid && i_wr_ready) begin
                    // Byte arriving in the handshake cycle is judged as if already idle
                    w_wr_valid_nxt = 1'b0;
                    if (w_is_sync) begin
                        w_state_nxt = S_ADDR;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (i_valid) begin
                    w_err_valid = 1'b1;
                    w_err_code  = 2'd3;
                end else begin
                    w_state_nxt = S_OUT;
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_wr_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, payload and output registers
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_state     <= S_IDLE;
            r_timer     <= {LP_TW{1'b0}};
            r_addr      <= 8'h00;
            r_dhi       <= 8'h00;
            r_dlo       <= 8'h00;
            r_wr_valid  <= 1'b0;
            r_err_valid <= 1'b0;
            r_err_code  <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_wr_valid  <= w_wr_valid_nxt;
            r_err_valid <= w_err_valid;
            r_err_code  <= w_err_code;
            if (w_ld_addr) begin
                r_addr <= i_data;
            end
            if (w_ld_dhi) begin
                r_dhi <= i_data;
            end
            if (w_ld_dlo) begin
                r_dlo <= i_data;
            end
        end
    end

    assign o_wr_valid  = r_wr_valid;
    assign o_wr_addr   = r_addr;
    assign o_wr_data   = {r_dhi, r_dlo};
    assign o_err_valid = r_err_valid;
    assign o_err_code  = r_err_code;

endmodule
